// File: rtl/ifu_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch_if
//  Description : Instruction-fetch bundle: imem request/response channel,
//                decode-side instruction handshake and control-unit inputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface ifu_fetch_if;
    // imem request/response channel
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    // instruction presented to decode/datapath
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    // control-unit steering
    logic        PCSel;
    logic [31:0] pc_target;
    logic        EndSim;
    // status
    logic        halted;
    logic        fetch_err;
    logic [31:0] retire_cnt;

    // fetch unit side
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        output inst, inst_pc, inst_valid,
        input  inst_ready, PCSel, pc_target, EndSim,
        output halted, fetch_err, retire_cnt
    );

    // memory / control-unit side
    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
        input  inst, inst_pc, inst_valid,
        output inst_ready, PCSel, pc_target, EndSim,
        input  halted, fetch_err, retire_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ifu_fetch
//  Description : Single-outstanding instruction fetch unit. Issues one imem
//                request, waits for the response (with timeout), presents the
//                word to decode and advances the PC on commit. Faults, timeout,
//                misaligned jump targets and ebreak halt fetch until reset.
//  Revision    : 1.0  initial release
// ============================================================================
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  wire logic  clk,
    input  wire logic  rst,
    ifu_fetch_if.master bus
);

    localparam logic [1:0] c_st_fetch = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_issue = 2'd2;
    localparam logic [1:0] c_st_halt  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_retire_cnt;
    logic [7:0]  r_wait_cnt;
    logic        r_fetch_err;

    // Wait counter holds the index of the current WAIT cycle; the 9-bit sum
    // lets the timeout test work for any TIMEOUT including 255.
    logic [8:0]  w_wait_next;
    logic        w_timeout;
    logic        w_target_misaligned;

    assign w_wait_next         = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout           = (w_wait_next >= {1'b0, TIMEOUT});
    assign w_target_misaligned = (bus.pc_target[1:0] != 2'b00);

    // Handshake outputs are pure functions of state, never of inst_ready.
    assign bus.imem_req_valid = (r_state == c_st_fetch);
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = (r_state == c_st_issue);
    assign bus.inst           = r_inst;
    assign bus.inst_pc        = r_inst_pc;
    assign bus.halted         = (r_state == c_st_halt);
    assign bus.fetch_err      = r_fetch_err;
    assign bus.retire_cnt     = r_retire_cnt;

    // Fetch sequencer: request -> wait for response -> issue -> commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_fetch;
            r_pc         <= RESET_PC;
            r_inst       <= 32'h0;
            r_inst_pc    <= RESET_PC;
            r_retire_cnt <= 32'h0;
            r_wait_cnt   <= 8'h0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_fetch: begin
                    if (bus.imem_req_ready) begin
                        r_state    <= c_st_wait;
                        r_wait_cnt <= 8'h0;
                    end
                end
                c_st_wait: begin
                    if (bus.imem_resp_valid) begin
                        if (bus.imem_resp_err) begin
                            r_state     <= c_st_halt;
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_inst    <= bus.imem_resp_data;
                            r_inst_pc <= r_pc;
                            r_state   <= c_st_issue;
                        end
                    end else if (w_timeout) begin
                        r_state     <= c_st_halt;
                        r_fetch_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_next[7:0];
                    end
                end
                c_st_issue: begin
                    // Control inputs only matter on the commit cycle.
                    if (bus.inst_ready) begin
                        if (bus.EndSim) begin
                            r_retire_cnt <= r_retire_cnt + 32'd1;
                            r_state      <= c_st_halt;
                        end else if (bus.PCSel && w_target_misaligned) begin
                            r_state     <= c_st_halt;
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_retire_cnt <= r_retire_cnt + 32'd1;
                            r_pc         <= bus.PCSel ? bus.pc_target : (r_pc + 32'd4);
                            r_state      <= c_st_fetch;
                        end
                    end
                end
                default: begin
                    // HALT is sticky until reset.
                    r_state <= c_st_halt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifu_fetch
//  Description : Self-checking bench for ifu_fetch. A transaction-level model
//                tracks PC, retire count, halt and fault status; each directed
//                or randomised transaction is checked against it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifu_fetch;

    localparam logic [31:0] c_reset_pc = 32'h8000_0000;
    localparam logic [7:0]  c_timeout  = 8'd255;

    logic clk;
    logic rst;
    ifu_fetch_if bus ();

    ifu_fetch #(
        .RESET_PC (c_reset_pc),
        .TIMEOUT  (c_timeout)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_retire;
    logic [31:0] m_inst;
    logic        m_halted;
    logic        m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.PCSel           = 1'b0;
        bus.pc_target       = 32'h0;
        bus.EndSim          = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        m_pc = c_reset_pc; m_retire = 32'h0; m_inst = 32'h0;
        m_halted = 1'b0; m_err = 1'b0;
        chk("rst_req_valid", bus.imem_req_valid, 1);
        chk("rst_req_addr", bus.imem_req_addr, c_reset_pc);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, c_reset_pc);
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_retire", bus.retire_cnt, 32'h0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_fetch_err", bus.fetch_err, 0);
    endtask

    // Accept the pending request (DUT expected in FETCH at m_pc).
    task automatic accept(input int req_stall);
        chk("fetch_req_valid", bus.imem_req_valid, 1);
        chk("fetch_req_addr", bus.imem_req_addr, m_pc);
        chk("fetch_inst_valid", bus.inst_valid, 0);
        for (int i = 0; i < req_stall; i++) begin
            bus.imem_req_ready  = 1'b0;
            bus.imem_resp_valid = 1'($urandom_range(0, 1));
            tick();
            chk("stall_req_valid", bus.imem_req_valid, 1);
            chk("stall_req_addr", bus.imem_req_addr, m_pc);
        end
        bus.imem_resp_valid = 1'b0;
        bus.imem_req_ready  = 1'b1;
        tick();
        bus.imem_req_ready  = 1'b0;
        chk("wait_req_valid", bus.imem_req_valid, 0);
    endtask

    // One complete instruction: fetch, respond, backpressure, commit.
    task automatic xact(input int req_stall, input int resp_delay, input int ready_delay,
                        input bit pcsel, input logic [31:0] tgt, input bit endsim,
                        input logic [31:0] data);
        accept(req_stall);
        for (int i = 0; i < resp_delay; i++) begin
            tick();
            chk("wait_req_valid", bus.imem_req_valid, 0);
            chk("wait_inst_valid", bus.inst_valid, 0);
        end
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = data;
        bus.imem_resp_err   = 1'b0;
        tick();
        bus.imem_resp_valid = 1'b0;
        m_inst = data;
        chk("issue_inst_valid", bus.inst_valid, 1);
        chk("issue_inst", bus.inst, data);
        chk("issue_inst_pc", bus.inst_pc, m_pc);
        for (int i = 0; i < ready_delay; i++) begin
            bus.inst_ready      = 1'b0;
            bus.PCSel           = 1'($urandom_range(0, 1));
            bus.pc_target       = $urandom;
            bus.EndSim          = 1'($urandom_range(0, 1));
            bus.imem_resp_valid = 1'($urandom_range(0, 1));
            bus.imem_resp_err   = 1'($urandom_range(0, 1));
            tick();
            chk("bp_inst", bus.inst, data);
            chk("bp_inst_pc", bus.inst_pc, m_pc);
            chk("bp_inst_valid", bus.inst_valid, 1);
            chk("bp_req_valid", bus.imem_req_valid, 0);
            chk("bp_retire", bus.retire_cnt, m_retire);
        end
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_err   = 1'b0;
        bus.inst_ready      = 1'b1;
        bus.PCSel           = pcsel;
        bus.pc_target       = tgt;
        bus.EndSim          = endsim;
        tick();
        bus.inst_ready = 1'b0;
        bus.PCSel      = 1'b0;
        bus.EndSim     = 1'b0;
        if (endsim) begin
            m_retire = m_retire + 32'd1;
            m_halted = 1'b1;
        end else if (pcsel && (tgt % 4 != 0)) begin
            m_halted = 1'b1;
            m_err    = 1'b1;
        end else begin
            m_retire = m_retire + 32'd1;
            m_pc     = pcsel ? tgt : m_pc + 32'd4;
        end
        chk("commit_halted", bus.halted, m_halted);
        chk("commit_fetch_err", bus.fetch_err, m_err);
        chk("commit_retire", bus.retire_cnt, m_retire);
        if (m_halted) begin
            chk("commit_halt_req_valid", bus.imem_req_valid, 0);
            chk("commit_halt_inst_valid", bus.inst_valid, 0);
        end else begin
            chk("commit_next_req_valid", bus.imem_req_valid, 1);
            chk("commit_next_addr", bus.imem_req_addr, m_pc);
        end
    endtask

    // Halt must be sticky whatever the inputs do.
    task automatic idle_halted(input int n);
        for (int i = 0; i < n; i++) begin
            bus.imem_req_ready  = 1'b1;
            bus.imem_resp_valid = 1'($urandom_range(0, 1));
            bus.imem_resp_err   = 1'($urandom_range(0, 1));
            bus.imem_resp_data  = $urandom;
            bus.inst_ready      = 1'($urandom_range(0, 1));
            bus.PCSel           = 1'($urandom_range(0, 1));
            bus.EndSim          = 1'($urandom_range(0, 1));
            tick();
            chk("halt_req_valid", bus.imem_req_valid, 0);
            chk("halt_inst_valid", bus.inst_valid, 0);
            chk("halt_halted", bus.halted, 1);
            chk("halt_fetch_err", bus.fetch_err, m_err);
            chk("halt_retire", bus.retire_cnt, m_retire);
            chk("halt_inst", bus.inst, m_inst);
        end
        clear_inputs();
    endtask

    initial begin
        logic [31:0] tgt;
        clk = 1'b0;
        rst = 1'b1;
        clear_inputs();

        // sequential fetch, zero wait states: one instruction every 3 cycles
        do_reset();
        for (int i = 0; i < 3; i++)
            xact(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
        chk("seq_pc", bus.imem_req_addr, 32'h8000_000C);

        // aligned jump from 8000_0004, then backpressure
        do_reset();
        xact(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
        xact(0, 0, 0, 1'b1, 32'h8000_0100, 1'b0, $urandom);
        xact(1, 2, 5, 1'b0, 32'h0, 1'b0, $urandom);

        // randomised traffic with aligned targets
        for (int n = 0; n < 16; n++) begin
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            xact($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), tgt, 1'b0, $urandom);
        end

        // misaligned target: halt with fault, no retire
        xact(0, 0, 0, 1'b1, 32'h8000_0102, 1'b0, $urandom);
        idle_halted(3);

        // response access fault
        do_reset();
        xact(0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h1234_5678);
        accept(0);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_err   = 1'b1;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        clear_inputs();
        m_halted = 1'b1; m_err = 1'b1;
        chk("err_halted", bus.halted, 1);
        chk("err_fetch_err", bus.fetch_err, 1);
        chk("err_inst", bus.inst, m_inst);
        idle_halted(3);

        // response timeout: 255 WAIT cycles without a response
        do_reset();
        accept(0);
        for (int i = 0; i < int'(c_timeout) - 1; i++) tick();
        chk("to_not_yet_halted", bus.halted, 0);
        chk("to_wait_req_valid", bus.imem_req_valid, 0);
        tick();
        m_halted = 1'b1; m_err = 1'b1;
        chk("to_halted", bus.halted, 1);
        chk("to_fetch_err", bus.fetch_err, 1);
        idle_halted(3);

        // ebreak: retire then clean halt
        do_reset();
        xact(0, 1, 0, 1'b0, 32'h0, 1'b1, 32'h0010_0073);
        idle_halted(4);

        // reset in the middle of WAIT, stale response arrives in FETCH
        do_reset();
        accept(0);
        do_reset();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hCAFE_F00D;
        tick();
        bus.imem_resp_valid = 1'b0;
        chk("stale_req_valid", bus.imem_req_valid, 1);
        chk("stale_req_addr", bus.imem_req_addr, c_reset_pc);
        chk("stale_inst_valid", bus.inst_valid, 0);
        chk("stale_inst", bus.inst, 32'h0);

        // PC wrap-around FFFF_FFFC + 4 -> 0
        xact(0, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, $urandom);
        xact(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);
        xact(0, 0, 0, 1'b0, 32'h0, 1'b0, $urandom);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
